// File: rtl/store_buffer.sv
// Posted-write store buffer: FIFO between memory stage and data memory,
// with word-granular store-to-load forwarding from pending entries.
module store_buffer #(
   parameter int DEPTH = 4,
   parameter int AW    = 32,
   parameter int DW    = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     memwrite,
   input  logic [AW-1:0]            dataaddr,
   input  logic [DW-1:0]            writedata,
   input  logic [AW-1:0]            ld_addr,
   output logic                     ld_hit,
   output logic [DW-1:0]            ld_data,
   output logic                     stall,
   output logic                     mem_we,
   output logic [AW-1:0]            mem_addr,
   output logic [DW-1:0]            mem_wdata,
   input  logic                     mem_ready,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

   logic [AW-1:0] addr_q [DEPTH];
   logic [DW-1:0] data_q [DEPTH];
   logic [PW-1:0] wp;
   logic [PW-1:0] rp;
   logic [PW-1:0] fidx;
   logic          push;
   logic          pop;
   logic          ld_off_unused;

   assign stall     = (count == FULL);
   assign mem_we    = (count != '0);
   assign push      = memwrite && !stall;
   assign pop       = mem_we && mem_ready;
   assign mem_addr  = mem_we ? addr_q[rp] : '0;
   assign mem_wdata = mem_we ? data_q[rp] : '0;

   assign ld_off_unused = ^ld_addr[1:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop)  rp <= rp + 1'b1;
         if (push && !pop)
            count <= count + 1'b1;
         else if (pop && !push)
            count <= count - 1'b1;
      end
   end

   // Entry storage needs no reset; validity comes from rp/count.
   always_ff @(posedge clk) begin
      if (!reset && push) begin
         addr_q[wp] <= dataaddr;
         data_q[wp] <= writedata;
      end
   end

   // Walk oldest to newest so the last match left standing is the newest.
   always_comb begin
      ld_hit  = 1'b0;
      ld_data = '0;
      fidx    = rp;
      for (int k = 0; k < DEPTH; k++) begin
         fidx = rp + PW'(k);
         if ((PW+1)'(k) < count &&
             addr_q[fidx][AW-1:2] == ld_addr[AW-1:2]) begin
            ld_hit  = 1'b1;
            ld_data = data_q[fidx];
         end
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: stimulus queues expected drains,
// a negedge monitor compares every drained entry and occupancy flags.
module tb_store_buffer;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        memwrite = 1'b0;
   logic [31:0] dataaddr = '0;
   logic [31:0] writedata = '0;
   logic [31:0] ld_addr = '0;
   logic        ld_hit;
   logic [31:0] ld_data;
   logic        stall;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ready = 1'b0;
   logic [2:0]  count;

   int total = 0;
   int bad = 0;
   int mcount = 0;
   logic [63:0] exp_q[$];

   store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
      .clk(clk), .reset(reset), .memwrite(memwrite),
      .dataaddr(dataaddr), .writedata(writedata),
      .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
      .stall(stall), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ready(mem_ready), .count(count)
   );

   always #5 clk = ~clk;

   function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endfunction

   // Reference occupancy model: acceptance decided from pre-edge count.
   always @(posedge clk) begin
      if (reset) begin
         mcount = 0;
         exp_q.delete();
      end else begin
         logic p, q;
         p = memwrite && mcount != DEPTH;
         q = mcount != 0 && mem_ready;
         if (p) exp_q.push_back({dataaddr, writedata});
         mcount = mcount + int'(p) - int'(q);
      end
   end

   always @(negedge clk) begin
      chk("count", 32'(count), 32'(mcount));
      chk("stall", 32'(stall), 32'(mcount == DEPTH));
      chk("mem_we", 32'(mem_we), 32'(mcount != 0));
      if (!mem_we) begin
         chk("idle_addr", mem_addr, 32'h0);
         chk("idle_wdata", mem_wdata, 32'h0);
      end else if (!reset && mem_ready) begin
         if (exp_q.size() == 0) begin
            chk("drain_unexpected", 32'h1, 32'h0);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            chk("drain_addr", mem_addr, e[63:32]);
            chk("drain_data", mem_wdata, e[31:0]);
         end
      end
   end

   task automatic step(input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic rdy);
      @(posedge clk);
      #1;
      memwrite  = we;
      dataaddr  = a;
      writedata = d;
      mem_ready = rdy;
   endtask

   task automatic drain();
      for (int i = 0; i < 30 && mcount != 0; i++) step(1'b0, 0, 0, 1'b1);
      chk("drain_bound", 32'(mcount), 32'h0);
      step(1'b0, 0, 0, 1'b0);
   endtask

   task automatic ld_chk(input logic [31:0] a, input logic h,
                         input logic [31:0] d);
      ld_addr = a;
      #1;
      chk("ld_hit", 32'(ld_hit), 32'(h));
      chk("ld_data", ld_data, d);
   endtask

   initial begin
      // reset with stores presented
      reset = 1'b1;
      memwrite = 1'b1; dataaddr = 32'h20; writedata = 32'h55;
      step(1'b1, 32'h20, 32'h55, 1'b0);
      step(1'b1, 32'h24, 32'h66, 1'b0);
      reset = 1'b0;
      memwrite = 1'b0;
      step(1'b0, 0, 0, 1'b0);
      step(1'b0, 0, 0, 1'b0);
      chk("rst_count", 32'(count), 32'h0);
      chk("rst_stall", 32'(stall), 32'h0);
      chk("rst_mem_we", 32'(mem_we), 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      ld_chk(32'h20, 1'b0, 32'h0);

      // single store, 1-cycle latency
      step(1'b1, 32'h8, 32'h3, 1'b1);
      step(1'b0, 0, 0, 1'b1);
      chk("single_we", 32'(mem_we), 32'h1);
      chk("single_addr", mem_addr, 32'h8);
      chk("single_data", mem_wdata, 32'h3);
      step(1'b0, 0, 0, 1'b0);
      chk("single_empty_cnt", 32'(count), 32'h0);
      chk("single_empty_we", 32'(mem_we), 32'h0);

      // fill and drain with a held fifth store
      step(1'b1, 32'h0, 32'h1, 1'b0);
      step(1'b1, 32'h4, 32'h2, 1'b0);
      step(1'b1, 32'h8, 32'h3, 1'b0);
      step(1'b1, 32'hC, 32'h4, 1'b0);
      step(1'b1, 32'h10, 32'h5, 1'b0);
      step(1'b1, 32'h10, 32'h5, 1'b0);
      chk("full_count", 32'(count), 32'h4);
      chk("full_stall", 32'(stall), 32'h1);
      step(1'b1, 32'h10, 32'h5, 1'b1);
      chk("full_stall_hold", 32'(stall), 32'h1);
      step(1'b1, 32'h10, 32'h5, 1'b1);
      chk("stall_fall", 32'(stall), 32'h0);
      chk("after_pop_cnt", 32'(count), 32'h3);
      step(1'b0, 0, 0, 1'b1);
      chk("refill_cnt", 32'(count), 32'h3);
      drain();

      // forwarding: newest match wins, offset ignored
      step(1'b1, 32'h8, 32'h3, 1'b0);
      step(1'b1, 32'h8, 32'h7, 1'b0);
      step(1'b0, 0, 0, 1'b0);
      ld_chk(32'h8, 1'b1, 32'h7);
      ld_chk(32'hA, 1'b1, 32'h7);
      ld_chk(32'hC, 1'b0, 32'h0);
      ld_addr = '0;
      drain();

      // simultaneous push/pop across several wraps
      step(1'b1, 32'h100, 32'hA0, 1'b0);
      step(1'b1, 32'h104, 32'hA1, 1'b0);
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 32'h200 + 32'(4 * i), 32'hB0 + 32'(i), 1'b1);
         if (i > 0) chk("pp_count", 32'(count), 32'h2);
      end
      drain();

      // reset mid-drain discards pending entries
      step(1'b1, 32'h30, 32'hC0, 1'b0);
      step(1'b1, 32'h34, 32'hC1, 1'b0);
      step(1'b1, 32'h38, 32'hC2, 1'b0);
      step(1'b0, 0, 0, 1'b1);
      reset = 1'b1;
      step(1'b0, 0, 0, 1'b1);
      reset = 1'b0;
      chk("mid_rst_count", 32'(count), 32'h0);
      chk("mid_rst_we", 32'(mem_we), 32'h0);
      step(1'b1, 32'h40, 32'h9, 1'b1);
      step(1'b0, 0, 0, 1'b1);
      chk("post_rst_addr", mem_addr, 32'h40);
      chk("post_rst_data", mem_wdata, 32'h9);
      drain();
      chk("queue_empty", 32'(exp_q.size()), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the MIPS pipeline's memory stage and the data memory. It captures each store the pipeline issues (`memwrite`, `dataaddr`, `writedata`) into a small FIFO and drains entries to data memory under a ready handshake, so a slow memory does not stall the pipeline on every store. It forwards buffered store data to loads whose word address matches a pending entry. It raises `stall` when full.

## Interface
- `DEPTH`, default 4: number of entries; power of two, ≥2.
- `AW`, default 32: address width.
- `DW`, default 32: data width.

Ports:
- `clk` input 1: clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-high; clears all state.
- `memwrite` input 1: store request from memory stage.
- `dataaddr` input AW: store byte address.
- `writedata` input DW: store data.
- `ld_addr` input AW: load byte address for forwarding lookup.
- `ld_hit` output 1: a pending entry matches `ld_addr` at word granularity.
- `ld_data` output DW: data of the newest matching entry; 0 when no hit.
- `stall` output 1: buffer full; upstream must hold the store.
- `mem_we` output 1: head entry valid toward data memory.
- `mem_addr` output AW: head entry address.
- `mem_wdata` output DW: head entry data.
- `mem_ready` input 1: data memory accepts the head entry this cycle.
- `count` output clog2(DEPTH)+1: current occupancy.

## Operation
- Storage: circular array of DEPTH {addr, data} entries, with write pointer `wp`, read pointer `rp` (clog2(DEPTH) bits, wrap modulo DEPTH) and `count`.
- Push: `memwrite && count != DEPTH`. Writes the entry at `wp` and increments `wp`. A `memwrite` while full is ignored; upstream holds it because `stall` = 1.
- Pop: `mem_we && mem_ready`. Increments `rp`.
- Count update:
  - push only: +1.
  - pop only: −1.
  - both in one cycle: unchanged, with both pointers advancing.
  - neither: unchanged.
- Push is evaluated against `count` before the edge. A push at count = DEPTH is rejected even if a pop occurs in the same cycle; the held store is accepted next cycle.
- Drain outputs:
  - `mem_we` = (count != 0).
  - `mem_addr` and `mem_wdata` = entry at `rp`; 0 when empty.
  - Entries drain in strict FIFO order. No coalescing; duplicate addresses drain individually.
- `stall` = (count == DEPTH), combinational from registered count.
- Forwarding:
  - Compare `ld_addr[AW-1:2]` with each valid entry's `addr[AW-1:2]`.
  - `ld_hit` = any match. `ld_data` = data of the match closest to `wp` (newest).
  - Byte offset bits [1:0] are ignored; full-word stores only.
  - The store presented on `memwrite` in the same cycle is not forwarded; only registered entries are.
  - An entry popping in the current cycle still forwards during that cycle.
- Reset: `wp` = `rp` = 0 and `count` = 0. All pending entries are discarded, including mid-drain.

## Timing
- Reset values: `stall` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, `ld_hit` 0, `ld_data` 0, `count` 0.
- Store-to-memory latency is 1 cycle. A store accepted at edge N appears on `mem_*` after edge N if the buffer was empty.
- Throughput is one push and one pop per cycle.
- `ld_hit` and `ld_data` are combinational from `ld_addr` and registered entries, valid in the same cycle.
- `stall` rises the cycle after the push that fills the buffer. It falls the cycle after the first pop from full.
- `reset` has priority over push and pop in the same cycle.

## Test plan
1. Reset: hold `reset`=1 for 2 cycles with `memwrite`=1 → after release, all outputs 0 and `count`=0. The stores presented during reset are not buffered.
2. Single store: `dataaddr`=8, `writedata`=3, `mem_ready`=1 for one cycle → next cycle `mem_we`=1, `mem_addr`=8, `mem_wdata`=3. The cycle after that, `count`=0 and `mem_we`=0.
3. Fill and drain:
   - With `mem_ready`=0, store (0x0,1), (0x4,2), (0x8,3), (0xC,4), then hold (0x10,5) → `count`=4 and `stall`=1; the 5th store is not accepted.
   - Raise `mem_ready` → drains 1, 2, 3, 4 on consecutive cycles. The 5th store is accepted the cycle after the first pop and drains 5th.
4. Forwarding: with `mem_ready`=0, store (8,3) then (8,7).
   - `ld_addr`=8 → `ld_hit`=1, `ld_data`=7.
   - `ld_addr`=0xA → `ld_hit`=1, `ld_data`=7.
   - `ld_addr`=0xC → `ld_hit`=0, `ld_data`=0.
5. Simultaneous push/pop at `count`=2 with `mem_ready`=1 → `count` stays 2, order preserved. Run through ≥2 pointer wrap-arounds with a DEPTH-deep scoreboard.
6. Reset mid-drain: with 3 entries pending, assert `reset` for one cycle → next cycle `count`=0 and `mem_we`=0. No stale entry reappears on later pushes.
